// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Producer-side hazard tracker for the Buraq-mini RV32IM pipeline. The block
// remembers which destination registers still wait on a long-latency result
// (loads and multi-cycle MUL/DIV). It stalls decode while an instruction reads
// or overwrites such a register, or while it needs the busy MUL/DIV unit.
//
// Parameters
//   RegAddrWidth : register address width; the scoreboard holds 2**RegAddrWidth bits
//   MulDivLat    : cycles the MUL/DIV unit stays occupied after issue (1..15)
//
// Ports
//   clk, rst_n          : core clock, asynchronous active-low reset
//   ID_valid            : decode holds a valid instruction
//   ID_RS1/ID_RS2       : decode source addresses
//   ID_RS1_used/_RS2_.. : instruction actually reads that source
//   ID_RD, ID_RD_wen    : decode destination and its write enable
//   ID_is_load          : instruction is a load
//   ID_is_muldiv        : instruction uses the multi-cycle MUL/DIV unit
//   Flush               : kills the decode instruction this cycle
//   WB_RD, WB_long_wen  : long-latency result retiring this cycle
//   Stall_decode        : hold PC and IF/ID, inject a bubble into ID/EX
//   MulDiv_busy         : MUL/DIV unit occupied
//   Pending_map         : scoreboard, bit n set while xn is pending
//
// Optional feature (macro HAZ_STALL_STATS_EN)
//   Adds Stall_cycles[31:0] (cycles with Stall_decode high) and
//   Raw_stall_cycles[31:0] (stalled cycles where the RAW term is true).
//   Both counters saturate at all-ones.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int RegAddrWidth = 5,
    parameter int MulDivLat    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ID_valid,
    input  logic [RegAddrWidth-1:0]        ID_RS1,
    input  logic [RegAddrWidth-1:0]        ID_RS2,
    input  logic                           ID_RS1_used,
    input  logic                           ID_RS2_used,
    input  logic [RegAddrWidth-1:0]        ID_RD,
    input  logic                           ID_RD_wen,
    input  logic                           ID_is_load,
    input  logic                           ID_is_muldiv,
    input  logic                           Flush,
    input  logic [RegAddrWidth-1:0]        WB_RD,
    input  logic                           WB_long_wen,
    output logic                           Stall_decode,
    output logic                           MulDiv_busy,
    output logic [(2**RegAddrWidth)-1:0]   Pending_map
`ifdef HAZ_STALL_STATS_EN
    ,
    output logic [31:0]                    Stall_cycles,
    output logic [31:0]                    Raw_stall_cycles
`endif
);

    localparam int         NumRegs = 2 ** RegAddrWidth;
    localparam logic [3:0] LatLoad = 4'(MulDivLat);

    if (MulDivLat < 1 || MulDivLat > 15) begin : g_bad_lat
        $error("hazard_scoreboard: MulDivLat must be in 1..15");
    end

    logic [NumRegs-1:0] pending_q;
    logic [NumRegs-1:0] pending_d;
    logic [NumRegs-1:0] clr_vec;
    logic [NumRegs-1:0] set_vec;
    logic [3:0]         occ_q;
    logic [3:0]         occ_d;

    logic raw_hit;
    logic waw_hit;
    logic struct_hit;
    logic long_op;
    logic issue;

    // Hazard checks look only at the registered scoreboard; a same-cycle
    // writeback is bypassed by the forwarding unit, not here.
    assign raw_hit    = (ID_RS1_used && (ID_RS1 != '0) && pending_q[ID_RS1]) ||
                        (ID_RS2_used && (ID_RS2 != '0) && pending_q[ID_RS2]);
    assign waw_hit    = ID_RD_wen && (ID_RD != '0) && pending_q[ID_RD];
    assign struct_hit = ID_is_muldiv && MulDiv_busy;

    // A flushed or empty decode slot never stalls the front end.
    assign Stall_decode = ID_valid && !Flush && (raw_hit || waw_hit || struct_hit);
    assign issue        = ID_valid && !Flush && !Stall_decode;
    assign long_op      = ID_RD_wen && (ID_is_load || ID_is_muldiv) && (ID_RD != '0);

    assign Pending_map = pending_q;
    assign MulDiv_busy = (occ_q != 4'd0);

    // NOTE: every signal written in this always_comb gets a default first, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (WB_long_wen && (WB_RD != '0)) begin
            clr_vec[WB_RD] = 1'b1;
        end
        if (issue && long_op) begin
            set_vec[ID_RD] = 1'b1;
        end
        // Clear first, then set: a new producer wins over a retiring one.
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        occ_d = occ_q;
        if (issue && ID_is_muldiv) begin
            occ_d = LatLoad;
        end else if (occ_q != 4'd0) begin
            occ_d = occ_q - 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            occ_q     <= 4'd0;
        end else begin
            pending_q <= pending_d;
            occ_q     <= occ_d;
        end
    end

`ifdef HAZ_STALL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stall_cycles     <= 32'd0;
            Raw_stall_cycles <= 32'd0;
        end else begin
            if (Stall_decode && (Stall_cycles != 32'hFFFF_FFFF)) begin
                Stall_cycles <= Stall_cycles + 32'd1;
            end
            if (Stall_decode && raw_hit && (Raw_stall_cycles != 32'hFFFF_FFFF)) begin
                Raw_stall_cycles <= Raw_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Bench for hazard_scoreboard (RegAddrWidth = 5, MulDivLat = 4). A table of
// per-cycle stimulus with hand-derived outputs covers the directed scenarios;
// a hand-written sequence covers asynchronous reset mid-run; a random phase
// compares against a reference model that tracks pending registers as a
// per-register array and MUL/DIV occupancy as "busy until cycle N".
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_wen;
    logic        id_is_load;
    logic        id_is_muldiv;
    logic        flush;
    logic [4:0]  wb_rd;
    logic        wb_long_wen;
    logic        stall_decode;
    logic        muldiv_busy;
    logic [31:0] pending_map;
`ifdef HAZ_STALL_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] raw_stall_cycles;
`endif

    hazard_scoreboard #(.RegAddrWidth(5), .MulDivLat(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ID_valid     (id_valid),
        .ID_RS1       (id_rs1),
        .ID_RS2       (id_rs2),
        .ID_RS1_used  (id_rs1_used),
        .ID_RS2_used  (id_rs2_used),
        .ID_RD        (id_rd),
        .ID_RD_wen    (id_rd_wen),
        .ID_is_load   (id_is_load),
        .ID_is_muldiv (id_is_muldiv),
        .Flush        (flush),
        .WB_RD        (wb_rd),
        .WB_long_wen  (wb_long_wen),
        .Stall_decode (stall_decode),
        .MulDiv_busy  (muldiv_busy),
        .Pending_map  (pending_map)
`ifdef HAZ_STALL_STATS_EN
        ,
        .Stall_cycles     (stall_cycles),
        .Raw_stall_cycles (raw_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       rs1_used;
        logic [4:0] rs2;
        logic       rs2_used;
        logic [4:0] rd;
        logic       rd_wen;
        logic       is_load;
        logic       is_muldiv;
        logic       flush;
        logic [4:0] wb_rd;
        logic       wb_wen;
    } in_t;

    typedef struct {
        in_t         in;
        logic        stall;
        logic        busy;
        logic [31:0] map;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_pend [32];
    int cyc        = 0;
    int busy_until = -1;

    function automatic in_t mk(int valid, int rs1, int rs1u, int rs2, int rs2u,
                               int rd, int rdw, int ld, int md, int fl,
                               int wbrd, int wbw);
        in_t v;
        v.valid     = 1'(valid);
        v.rs1       = 5'(rs1);
        v.rs1_used  = 1'(rs1u);
        v.rs2       = 5'(rs2);
        v.rs2_used  = 1'(rs2u);
        v.rd        = 5'(rd);
        v.rd_wen    = 1'(rdw);
        v.is_load   = 1'(ld);
        v.is_muldiv = 1'(md);
        v.flush     = 1'(fl);
        v.wb_rd     = 5'(wbrd);
        v.wb_wen    = 1'(wbw);
        return v;
    endfunction

    task automatic tv(input in_t v, input int s, input int b, input int m);
        vec_t e;
        e.in    = v;
        e.stall = 1'(s);
        e.busy  = 1'(b);
        e.map   = 32'(m);
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        id_valid     = v.valid;
        id_rs1       = v.rs1;
        id_rs1_used  = v.rs1_used;
        id_rs2       = v.rs2;
        id_rs2_used  = v.rs2_used;
        id_rd        = v.rd;
        id_rd_wen    = v.rd_wen;
        id_is_load   = v.is_load;
        id_is_muldiv = v.is_muldiv;
        flush        = v.flush;
        wb_rd        = v.wb_rd;
        wb_long_wen  = v.wb_wen;
    endtask

    // Expected outputs for the current cycle, straight from the hazard rules.
    task automatic model_outputs(input in_t v, output logic s, output logic b, output logic [31:0] m);
        bit raw, waw, busy;
        busy = (cyc <= busy_until);
        raw  = (v.rs1_used && v.rs1 != 0 && m_pend[v.rs1]) ||
               (v.rs2_used && v.rs2 != 0 && m_pend[v.rs2]);
        waw  = v.rd_wen && v.rd != 0 && m_pend[v.rd];
        s    = v.valid && !v.flush && (raw || waw || (v.is_muldiv && busy));
        b    = busy;
        m    = '0;
        for (int i = 1; i < 32; i++) m[i] = m_pend[i];
    endtask

    task automatic model_commit(input in_t v, input logic stalled);
        bit issued;
        issued = v.valid && !v.flush && !stalled;
        if (v.wb_wen && v.wb_rd != 0) m_pend[v.wb_rd] = 1'b0;
        if (issued && v.rd_wen && (v.is_load || v.is_muldiv) && v.rd != 0) m_pend[v.rd] = 1'b1;
        if (issued && v.is_muldiv) busy_until = cyc + LAT;
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        busy_until = -1;
    endtask

    // One clock cycle: drive, compare (table values or model), clock, update model.
    task automatic run_cycle(input in_t v, input bit use_tbl, input logic e_s,
                             input logic e_b, input logic [31:0] e_m, input string tag);
        logic        m_s;
        logic        m_b;
        logic [31:0] m_m;
        @(negedge clk);
        drive(v);
        #1;
        model_outputs(v, m_s, m_b, m_m);
        if (use_tbl) begin
            check({tag, " stall"}, 32'(stall_decode), 32'(e_s));
            check({tag, " busy"},  32'(muldiv_busy),  32'(e_b));
            check({tag, " map"},   pending_map,       e_m);
        end else begin
            check({tag, " stall"}, 32'(stall_decode), 32'(m_s));
            check({tag, " busy"},  32'(muldiv_busy),  32'(m_b));
            check({tag, " map"},   pending_map,       m_m);
        end
        @(posedge clk);
        model_commit(v, m_s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t idle;
        in_t add_x6;
        in_t div_x11;
        in_t ld_x4;
        in_t rv;

        idle    = mk(0, 0,0, 0,0, 0,0,0,0, 0, 0,0);
        add_x6  = mk(1, 5,1, 1,1, 6,1,0,0, 0, 0,0);
        div_x11 = mk(1, 1,1, 2,1, 11,1,0,1, 0, 0,0);
        ld_x4   = mk(1, 0,0, 0,0, 4,1,1,0, 0, 0,0);

        // Load-use on x5, writeback at row 3 releases the stall at row 4
        tv(mk(1, 0,0, 0,0, 5,1,1,0, 0, 0,0), 0, 0, 32'h0);
        tv(add_x6, 1, 0, 32'h20);
        tv(add_x6, 1, 0, 32'h20);
        tv(mk(1, 5,1, 1,1, 6,1,0,0, 0, 5,1), 1, 0, 32'h20);
        tv(add_x6, 0, 0, 32'h0);
        tv(idle,   0, 0, 32'h0);
        // x0 is never tracked
        tv(mk(1, 0,0, 0,0, 0,1,1,0, 0, 0,0), 0, 0, 32'h0);
        tv(mk(1, 0,1, 0,1, 3,1,0,0, 0, 0,0), 0, 0, 32'h0);
        // Clear of an idle bit plus new load to the same register: set wins
        tv(mk(1, 0,0, 0,0, 7,1,1,0, 0, 7,1), 0, 0, 32'h0);
        tv(idle, 0, 0, 32'h80);
        tv(mk(0, 0,0, 0,0, 0,0,0,0, 0, 7,1), 0, 0, 32'h80);
        tv(idle, 0, 0, 32'h0);
        // MUL then DIV: structural stall for 4 cycles, DIV busy for 4 cycles
        tv(mk(1, 1,1, 2,1, 10,1,0,1, 0, 0,0), 0, 0, 32'h0);
        tv(div_x11, 1, 1, 32'h400);
        tv(div_x11, 1, 1, 32'h400);
        tv(div_x11, 1, 1, 32'h400);
        tv(div_x11, 1, 1, 32'h400);
        tv(mk(1, 1,1, 2,1, 11,1,0,1, 0, 10,1), 0, 0, 32'h400);
        tv(idle, 0, 1, 32'h800);
        tv(idle, 0, 1, 32'h800);
        tv(idle, 0, 1, 32'h800);
        tv(idle, 0, 1, 32'h800);
        tv(idle, 0, 0, 32'h800);
        tv(mk(0, 0,0, 0,0, 0,0,0,0, 0, 11,1), 0, 0, 32'h800);
        tv(idle, 0, 0, 32'h0);
        // Flushed load x9 with RAW on pending x3: no stall, no set, x3 kept
        tv(mk(1, 0,0, 0,0, 3,1,1,0, 0, 0,0), 0, 0, 32'h0);
        tv(mk(1, 3,1, 0,0, 9,1,1,0, 1, 0,0), 0, 0, 32'h8);
        tv(idle, 0, 0, 32'h8);
        tv(mk(0, 0,0, 0,0, 0,0,0,0, 0, 3,1), 0, 0, 32'h8);
        tv(idle, 0, 0, 32'h0);
        // WAW on x4
        tv(ld_x4, 0, 0, 32'h0);
        tv(ld_x4, 1, 0, 32'h10);
        tv(mk(1, 0,0, 0,0, 4,1,1,0, 0, 4,1), 1, 0, 32'h10);
        tv(ld_x4, 0, 0, 32'h0);
        tv(idle,  0, 0, 32'h10);
        tv(mk(0, 0,0, 0,0, 0,0,0,0, 0, 4,1), 0, 0, 32'h10);
        tv(idle,  0, 0, 32'h0);

        // Power-on reset
        rst_n = 1'b0;
        drive(idle);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("por stall", 32'(stall_decode), 32'd0);
        check("por busy",  32'(muldiv_busy),  32'd0);
        check("por map",   pending_map,       32'h0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_cycle(tbl[i].in, 1'b1, tbl[i].stall, tbl[i].busy, tbl[i].map,
                      $sformatf("row%0d", i));
        end

        // Reset mid-run: Pending_map = 0x24 (x2, x5), occupancy counter at 3
        run_cycle(mk(1, 0,0, 0,0, 2,1,1,0, 0, 0,0), 1'b0, 0, 0, 0, "rst_ld2");
        run_cycle(mk(1, 0,0, 0,0, 5,1,0,1, 0, 0,0), 1'b0, 0, 0, 0, "rst_mul5");
        run_cycle(idle, 1'b0, 0, 0, 0, "rst_idle");
        @(negedge clk);
        drive(mk(1, 5,1, 0,0, 6,1,0,1, 0, 0,0));
        #1;
        check("pre_rst stall", 32'(stall_decode), 32'd1);
        check("pre_rst busy",  32'(muldiv_busy),  32'd1);
        check("pre_rst map",   pending_map,       32'h24);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst stall", 32'(stall_decode), 32'd0);
        check("mid_rst busy",  32'(muldiv_busy),  32'd0);
        check("mid_rst map",   pending_map,       32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle);

        // Random traffic on x0..x7 against the reference model
        for (int n = 0; n < 2000; n++) begin
            rv.valid     = ($urandom_range(0, 7) != 0);
            rv.rs1       = 5'($urandom_range(0, 7));
            rv.rs1_used  = 1'($urandom_range(0, 1));
            rv.rs2       = 5'($urandom_range(0, 7));
            rv.rs2_used  = 1'($urandom_range(0, 1));
            rv.rd        = 5'($urandom_range(0, 7));
            rv.rd_wen    = ($urandom_range(0, 3) != 0);
            rv.is_load   = ($urandom_range(0, 2) == 0);
            rv.is_muldiv = !rv.is_load && ($urandom_range(0, 4) == 0);
            rv.flush     = ($urandom_range(0, 7) == 0);
            rv.wb_rd     = 5'($urandom_range(0, 7));
            rv.wb_wen    = ($urandom_range(0, 2) == 0);
            run_cycle(rv, 1'b0, 0, 0, 0, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Producer-side companion to the operand forwarding unit in the Buraq-mini RV32IM pipeline. It records which destination registers have long-latency writes still in flight: loads, and MUL/DIV ops on the multi-cycle unit. It stalls decode while a source or destination register depends on a result that forwarding cannot yet supply. It also tracks occupancy of the multi-cycle MUL/DIV unit.

Parameters:
RegAddrWidth, 5, register address width; the scoreboard has 2**RegAddrWidth bits.
MulDivLat, 4, cycles the MUL/DIV unit is occupied after issue; must be 1..15.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ID_valid  input  1  decode holds a valid instruction
ID_RS1  input  RegAddrWidth  decode source 1 address
ID_RS2  input  RegAddrWidth  decode source 2 address
ID_RS1_used  input  1  instruction reads RS1
ID_RS2_used  input  1  instruction reads RS2
ID_RD  input  RegAddrWidth  decode destination address
ID_RD_wen  input  1  instruction writes RD
ID_is_load  input  1  instruction is a load
ID_is_muldiv  input  1  instruction uses the multi-cycle MUL/DIV unit
Flush  input  1  branch/jump flush, kills the decode instruction this cycle
WB_RD  input  RegAddrWidth  register retiring a long-latency result
WB_long_wen  input  1  long-latency result written back this cycle
Stall_decode  output  1  hold PC and IF/ID, inject bubble into ID/EX
MulDiv_busy  output  1  MUL/DIV unit occupied
Pending_map  output  2**RegAddrWidth  current scoreboard, bit n = xn pending

Behaviour:
- Reset (async, rst_n low): Pending_map = 0, occupancy counter = 0, so MulDiv_busy = 0 and Stall_decode = 0.
- Long op: ID_RD_wen && (ID_is_load || ID_is_muldiv) && ID_RD != 0.
- Issue fires when ID_valid && !Stall_decode && !Flush.
- Stall_decode is combinational and requires ID_valid && !Flush. It is high if any of these holds:
  - RAW: (ID_RS1_used && RS1 != 0 && Pending_map[RS1]) || (ID_RS2_used && RS2 != 0 && Pending_map[RS2]).
  - WAW: ID_RD_wen && RD != 0 && Pending_map[RD].
  - Structural: ID_is_muldiv && MulDiv_busy.
- Stall_decode is never high when ID_valid = 0 or Flush = 1.
- Clear term: if WB_long_wen && WB_RD != 0, clear bit WB_RD.
- Set term: if issue fires with a long op, set bit ID_RD.
- Next state: Pending_map_next = (Pending_map & ~clr) | set.
  - Clear and set applied in the same cycle; set wins on the same register.
  - x0 is never set; Pending_map[0] reads 0 always.
- A clear of a bit already at 0 is ignored, with no error.
- RAW/WAW checks use the registered Pending_map. A writeback in cycle N releases the stall in cycle N+1; same-cycle bypass is the forwarding unit's job.
- Occupancy counter is 4 bits:
  - Loaded with MulDivLat on a MUL/DIV issue.
  - Otherwise decrements by 1 while nonzero, saturating at 0.
  - MulDiv_busy = (counter != 0).
  - A MUL/DIV issued in cycle N sets busy for cycles N+1 through N+MulDivLat.
- Flush: suppresses the set and counter load for the flushed instruction only. Already-set bits remain, because older in-flight producers still retire.
- Latency: Pending_map and MulDiv_busy update one cycle after the event; Stall_decode is same-cycle.

Optional Feature:
Macro HAZ_STALL_STATS_EN.
- Defined: adds output Stall_cycles[31:0], a counter that increments every cycle Stall_decode = 1.
  - Saturates at 32'hFFFF_FFFF; asynchronously reset to 0.
  - A second output Raw_stall_cycles[31:0] counts only cycles where the RAW term is true.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset mid-run with Pending_map = 32'h0000_0024 and counter 3: assert rst_n = 0 -> Pending_map = 0, MulDiv_busy = 0, Stall_decode = 0 immediately.
- Load x5 issues at cycle 0; cycle 1 decode add x6,x5,x1 -> Stall_decode = 1 until WB_long_wen with WB_RD = 5 at cycle 3. Stall_decode = 0 at cycle 4 and Pending_map[5] = 0.
- Load x0 issued -> Pending_map stays 0. Instruction reading x0 -> no stall.
- Same cycle: WB clears x7 and a new load to x7 issues -> Pending_map[7] = 1 next cycle.
- MulDivLat = 4: MUL at cycle 0, DIV decoded at cycle 1 -> Stall_decode = 1 for cycles 1-4. DIV issues cycle 5, MulDiv_busy high cycles 6-9.
- Load x9 with Flush = 1 -> no issue, Pending_map[9] = 0. Stall_decode = 0 during flush even if RAW conflicts; pre-existing bit x3 is retained through the flush.
